// File: rtl/router_fsm_if.sv
// Control/status bundle between the 1x3 router input side, register block and FIFOs
// and the router control FSM.
interface router_fsm_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic [ADDR_W-1:0]    dest_addr;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, dest_addr
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, dest_addr
  );
endinterface

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 packet router: decodes the header address and sequences
// the register block through header, payload, FIFO-full and parity phases.
module router_fsm #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
) (
  input  logic         clock,
  input  logic         reset,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  localparam int SEL_W = 1 << ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] dest_addr;
  logic [SEL_W-1:0]  empty_ext, soft_ext;
  logic              addr_valid;

  // Widen the per-port vectors to the full address range so any address indexes safely.
  always_comb begin
    empty_ext                  = '0;
    soft_ext                   = '0;
    empty_ext[NUM_PORTS-1:0]   = bus.fifo_empty;
    soft_ext[NUM_PORTS-1:0]    = bus.soft_reset;
    addr_valid = {1'b0, bus.data_in} < (ADDR_W+1)'(NUM_PORTS);
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      DA:  if (bus.pkt_valid && addr_valid)
             state_next = empty_ext[bus.data_in] ? LFD : WTE;
      WTE: if (empty_ext[dest_addr]) state_next = LFD;
      LFD: state_next = LD;
      LD:  if (bus.fifo_full)       state_next = FFS;
           else if (!bus.pkt_valid) state_next = LP;
      FFS: if (!bus.fifo_full) state_next = LAF;
      LAF: if (bus.parity_done)        state_next = DA;
           else if (bus.low_pkt_valid) state_next = LP;
           else                        state_next = LD;
      LP:  state_next = CPE;
      CPE: state_next = bus.fifo_full ? FFS : DA;
      default: state_next = DA;
    endcase
    // A read-side timeout on the selected port aborts the packet from any busy phase.
    if (state != DA && soft_ext[dest_addr]) state_next = DA;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= DA;
      dest_addr <= '0;
    end else begin
      state <= state_next;
      if (state == DA && bus.pkt_valid && addr_valid) dest_addr <= bus.data_in;
    end
  end

  assign bus.detect_add    = (state == DA);
  assign bus.lfd_state     = (state == LFD);
  assign bus.ld_state      = (state == LD);
  assign bus.laf_state     = (state == LAF);
  assign bus.full_state    = (state == FFS);
  assign bus.rst_int_reg   = (state == CPE);
  assign bus.write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
  assign bus.busy          = (state != DA) && (state != LD);
  assign bus.dest_addr     = dest_addr;

endmodule
